// File: rtl/io_mtimer.sv
// io_mtimer: memory-mapped machine timer (64-bit mtime/mtimecmp with prescaler)
// plus a small GPIO block, sitting on the core's word-addressed IO port.
//
// Ports:
//   clk, reset     single clock domain, asynchronous active-high reset
//   io_addr        byte address, bits [1:0] ignored
//   io_en, io_we   one-cycle access strobe and write qualifier
//   io_data_write  full-word write data
//   io_data_read   read data, registered one cycle after the read strobe
//   irq_mtimecmp   registered level interrupt: IE & (mtime >= mtimecmp)
//   gpio_out       GPIO output register
//   gpio_in        asynchronous GPIO inputs, double-flop synchronized
module io_mtimer #(
    parameter int unsigned GPIO_W       = 8,
    parameter logic [31:0] PRESCALE_RST = 32'd0,
    parameter logic [63:0] CMP_RST      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        io_addr,
    input  logic              io_en,
    input  logic              io_we,
    input  logic [31:0]       io_data_write,
    output logic [31:0]       io_data_read,
    output logic              irq_mtimecmp,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORD_W = 6;

    localparam logic [WORD_W-1:0] A_MTIME_LO = 6'h00;
    localparam logic [WORD_W-1:0] A_MTIME_HI = 6'h01;
    localparam logic [WORD_W-1:0] A_CMP_LO   = 6'h02;
    localparam logic [WORD_W-1:0] A_CMP_HI   = 6'h03;
    localparam logic [WORD_W-1:0] A_CTRL     = 6'h04;
    localparam logic [WORD_W-1:0] A_PRESCALE = 6'h05;
    localparam logic [WORD_W-1:0] A_GPIO_OUT = 6'h06;
    localparam logic [WORD_W-1:0] A_GPIO_IN  = 6'h07;

    logic [63:0]       r_mtime;
    logic [31:0]       r_hi_shadow;
    logic [63:0]       r_cmp;
    logic [1:0]        r_ctrl;        // [0]=EN, [1]=IE
    logic [31:0]       r_prescale;
    logic [31:0]       r_cnt;
    logic [GPIO_W-1:0] r_gpio_out;
    logic [GPIO_W-1:0] r_gpio_sync1;
    logic [GPIO_W-1:0] r_gpio_sync2;
    logic [DATA_W-1:0] r_rdata;
    logic              r_irq;

    logic [WORD_W-1:0] w_word;
    logic              w_wr;
    logic              w_rd;
    logic              w_tick;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused_addr;

    assign w_word        = io_addr[7:2];
    assign w_wr          = io_en & io_we;
    assign w_rd          = io_en & ~io_we;
    assign w_unused_addr = ^io_addr[1:0];

    // Prescaler terminal count: advance mtime this cycle.
    assign w_tick = r_ctrl[0] && (r_cnt == r_prescale);

    // Read mux; sees pre-update register values, so a tick cycle reads the old mtime.
    always_comb begin
        w_rdata = '0;
        case (w_word)
            A_MTIME_LO: w_rdata = r_mtime[31:0];
            A_MTIME_HI: w_rdata = r_hi_shadow;
            A_CMP_LO:   w_rdata = r_cmp[31:0];
            A_CMP_HI:   w_rdata = r_cmp[63:32];
            A_CTRL:     w_rdata = DATA_W'(r_ctrl);
            A_PRESCALE: w_rdata = r_prescale;
            A_GPIO_OUT: w_rdata = DATA_W'(r_gpio_out);
            A_GPIO_IN:  w_rdata = DATA_W'(r_gpio_sync2);
            default:    w_rdata = '0;
        endcase
    end

    // Read data register and MTIME_HI shadow captured alongside a MTIME_LO read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata     <= '0;
            r_hi_shadow <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rdata;
            if (w_word == A_MTIME_LO) begin
                r_hi_shadow <= r_mtime[63:32];
            end
        end
    end

    // Prescale counter; a PRESCALE write restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_wr && (w_word == A_PRESCALE)) begin
            r_cnt <= '0;
        end else if (r_ctrl[0]) begin
            r_cnt <= w_tick ? 32'd0 : r_cnt + 32'd1;
        end
    end

    // mtime: a software write to either half beats the tick increment, with no carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mtime <= '0;
        end else if (w_wr && (w_word == A_MTIME_LO)) begin
            r_mtime[31:0] <= io_data_write;
        end else if (w_wr && (w_word == A_MTIME_HI)) begin
            r_mtime[63:32] <= io_data_write;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // Configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmp      <= CMP_RST;
            r_ctrl     <= '0;
            r_prescale <= PRESCALE_RST;
            r_gpio_out <= '0;
        end else if (w_wr) begin
            case (w_word)
                A_CMP_LO:   r_cmp[31:0]  <= io_data_write;
                A_CMP_HI:   r_cmp[63:32] <= io_data_write;
                A_CTRL:     r_ctrl       <= io_data_write[1:0];
                A_PRESCALE: r_prescale   <= io_data_write;
                A_GPIO_OUT: r_gpio_out   <= io_data_write[GPIO_W-1:0];
                default:    ;
            endcase
        end
    end

    // GPIO input synchronizer and interrupt compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gpio_sync1 <= '0;
            r_gpio_sync2 <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_gpio_sync1 <= gpio_in;
            r_gpio_sync2 <= r_gpio_sync1;
            r_irq        <= r_ctrl[1] && (r_mtime >= r_cmp);
        end
    end

    assign io_data_read = r_rdata;
    assign irq_mtimecmp = r_irq;
    assign gpio_out     = r_gpio_out;

endmodule

// File: tb/tb_io_mtimer.sv
// Directed bench for io_mtimer: reset values, prescaled counting, carry with
// atomic LO/HI read, write/tick collision, interrupt, GPIO and unmapped access.
module tb_io_mtimer;

    localparam int unsigned GPIO_W = 8;

    logic              clk;
    logic              reset;
    logic [7:0]        io_addr;
    logic              io_en;
    logic              io_we;
    logic [31:0]       io_data_write;
    logic [31:0]       io_data_read;
    logic              irq_mtimecmp;
    logic [GPIO_W-1:0] gpio_out;
    logic [GPIO_W-1:0] gpio_in;

    int n_vec;
    int n_err;
    logic [31:0] rd;

    io_mtimer #(.GPIO_W(GPIO_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_addr       (io_addr),
        .io_en         (io_en),
        .io_we         (io_we),
        .io_data_write (io_data_write),
        .io_data_read  (io_data_read),
        .irq_mtimecmp  (irq_mtimecmp),
        .gpio_out      (gpio_out),
        .gpio_in       (gpio_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [31:0] data);
        io_addr = addr; io_data_write = data; io_we = 1'b1; io_en = 1'b1;
        @(posedge clk);
        #1;
        io_en = 1'b0; io_we = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] addr, output logic [31:0] data);
        io_addr = addr; io_we = 1'b0; io_en = 1'b1;
        @(posedge clk);
        #1;
        io_en = 1'b0;
        data = io_data_read;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; io_addr = '0; io_en = 1'b0; io_we = 1'b0;
        io_data_write = '0; gpio_in = '0;
        idle(2);
        reset = 1'b0;

        // Reset state
        check("rst_rdata", io_data_read, 32'h0);
        check("rst_irq", 32'(irq_mtimecmp), 32'h0);
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        io_read(8'h08, rd); check("rst_cmp_lo", rd, 32'hFFFF_FFFF);
        io_read(8'h0C, rd); check("rst_cmp_hi", rd, 32'hFFFF_FFFF);
        io_read(8'h14, rd); check("rst_prescale", rd, 32'h0);
        io_read(8'h00, rd); check("rst_mtime_lo", rd, 32'h0);

        // Counting: PRESCALE=3 -> one tick per 4 enabled cycles
        io_write(8'h14, 32'd3);
        io_write(8'h10, 32'd1);
        idle(40);
        io_read(8'h00, rd); check("cnt_lo_40cyc", rd, 32'd10);
        io_read(8'h04, rd); check("cnt_hi", rd, 32'd0);
        io_write(8'h10, 32'd0);
        io_read(8'h00, rd); check("cnt_frozen", rd, 32'd10);
        io_read(8'h10, rd); check("ctrl_rb", rd, 32'd0);

        // Carry and atomic LO/HI read with a tick every cycle
        io_write(8'h04, 32'h0);
        io_write(8'h00, 32'hFFFF_FFFF);
        io_write(8'h14, 32'd0);
        io_write(8'h10, 32'd1);
        io_read(8'h00, rd); check("atom_lo0", rd, 32'hFFFF_FFFF);
        io_read(8'h04, rd); check("atom_hi0_shadow", rd, 32'h0);
        io_read(8'h00, rd); check("atom_lo1", rd, 32'h1);
        io_read(8'h04, rd); check("atom_hi1", rd, 32'h1);

        // Collision: MTIME_LO write in a tick cycle wins, HI untouched
        io_write(8'h00, 32'h100);
        io_read(8'h00, rd); check("coll_lo", rd, 32'h100);
        io_read(8'h04, rd); check("coll_hi", rd, 32'h1);
        io_write(8'h10, 32'd0);

        // Interrupt: IE=0 keeps irq low even with mtime >= mtimecmp
        io_write(8'h04, 32'h0);
        io_write(8'h00, 32'h20);
        io_write(8'h0C, 32'h0);
        io_write(8'h08, 32'h10);
        idle(2);
        check("irq_ie0", 32'(irq_mtimecmp), 32'h0);
        io_read(8'h08, rd); check("cmp_lo_rb", rd, 32'h10);

        // Interrupt: mtime from 0, PRESCALE=0, CTRL=3; mtime hits 0x10 after 16 edges
        io_write(8'h00, 32'h0);
        io_write(8'h10, 32'd3);
        idle(16);
        check("irq_before", 32'(irq_mtimecmp), 32'h0);
        idle(1);
        check("irq_rise", 32'(irq_mtimecmp), 32'h1);
        io_write(8'h0C, 32'hFFFF_FFFF);
        check("irq_hold", 32'(irq_mtimecmp), 32'h1);
        idle(1);
        check("irq_fall", 32'(irq_mtimecmp), 32'h0);

        // GPIO out truncation and readback
        io_write(8'h18, 32'h1A5);
        check("gpio_out", 32'(gpio_out), 32'hA5);
        io_read(8'h18, rd); check("gpio_out_rb", rd, 32'hA5);

        // GPIO in through the two-flop synchronizer
        gpio_in = 8'h3C;
        io_read(8'h1C, rd); check("gpio_in_early", rd, 32'h0);
        idle(1);
        io_read(8'h1C, rd); check("gpio_in_sync", rd, 32'h3C);
        io_write(8'h1C, 32'h0);
        io_read(8'h1C, rd); check("gpio_in_ro", rd, 32'h3C);

        // Unmapped addresses: read 0, writes alter nothing
        io_read(8'h40, rd); check("unmapped_rd", rd, 32'h0);
        io_write(8'h40, 32'h0);
        io_write(8'h50, 32'h0);
        io_write(8'h58, 32'h0);
        io_read(8'h10, rd); check("unmapped_ctrl", rd, 32'h3);
        check("unmapped_gpio", 32'(gpio_out), 32'hA5);

        // Reset asserted during an in-flight read
        io_read(8'h18, rd); check("pre_rst_rd", rd, 32'hA5);
        io_addr = 8'h18; io_we = 1'b0; io_en = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_rdata", io_data_read, 32'h0);
        @(posedge clk);
        #1;
        io_en = 1'b0;
        check("rst_mid_rdata", io_data_read, 32'h0);
        check("rst_mid_irq", 32'(irq_mtimecmp), 32'h0);
        check("rst_mid_gpio", 32'(gpio_out), 32'h0);
        reset = 1'b0;
        io_read(8'h08, rd); check("rst2_cmp_lo", rd, 32'hFFFF_FFFF);
        io_read(8'h0C, rd); check("rst2_cmp_hi", rd, 32'hFFFF_FFFF);
        io_read(8'h10, rd); check("rst2_ctrl", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
